combo_lock_param: RTL

- Parametrised successor to the six-digit combination lock FSM. It sits between the switch/key debounce logic and the 7-segment display driver.
- Code length, code value, failed-attempt limit and lockout duration are all generic.
- New versus the fixed-length lock: a failed-attempt counter with timed lockout, a clear-to-retry path that preserves the fail count, and optional run-time reprogramming of the code.
- Outputs are mode and status only; 7-segment encoding stays in the display block.

---
 rtl/combo_lock_param_if.sv | 22 ++
 rtl/combo_lock_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_param_if.sv
// Bus between the debounced switch inputs, the combination lock and the display driver.
interface combo_lock_param_if;
    logic        enter;
    logic [3:0]  digit;
    logic        clear;
    logic        prog;
    logic [2:0]  mode;
    logic [3:0]  digit_idx;
    logic [3:0]  fail_cnt;
    logic        bad_digit;
    logic [15:0] lock_left;

    modport master (
        output enter, digit, clear, prog,
        input  mode, digit_idx, fail_cnt, bad_digit, lock_left
    );

    modport slave (
        input  enter, digit, clear, prog,
        output mode, digit_idx, fail_cnt, bad_digit, lock_left
    );
endinterface

// File: rtl/combo_lock_param.sv
// Parametrised combination lock with failed-attempt lockout.
// Optional run-time code programming is enabled by defining PROGRAM_CODE_EN.
module combo_lock_param #(
    parameter int unsigned CODE_LEN    = 6,
    parameter logic [59:0] CODE        = 60'h722297,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    combo_lock_param_if.slave   bus
);

    localparam int unsigned    CW        = 4 * CODE_LEN;
    localparam logic [CW-1:0]  CODE_INIT = CODE[CW-1:0];
    localparam logic [3:0]     LAST_IDX  = 4'(CODE_LEN - 1);
    localparam logic [3:0]     FAIL_MAX  = 4'(MAX_FAILS);
    localparam logic [15:0]    LOCK_INIT = 16'(LOCK_CYCLES);
    localparam logic [7:0]     SH_TOP    = 8'(4 * (CODE_LEN - 1));

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_CLOSED  = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROGRAM = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [3:0]     fail_q, fail_d;
    logic [15:0]    lock_q, lock_d;
    logic           mism_q, mism_d;
    logic           bad;
    logic           mism_n;
    logic [7:0]     digit_sh;
    logic [3:0]     code_digit;
    logic [CW-1:0]  code_cur;

    assign bad           = bus.digit > 4'd9;
    assign bus.bad_digit = bad;

    // Digit 0 sits in the most significant nibble of the code word.
    assign digit_sh   = SH_TOP - {2'b00, idx_q, 2'b00};
    assign code_digit = 4'(code_cur >> digit_sh);
    assign mism_n     = mism_q | bad | (bus.digit != code_digit);

`ifdef PROGRAM_CODE_EN
    logic [CW-1:0] code_q, code_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic [CW-1:0] shadow_wr;

    assign code_cur  = code_q;
    assign shadow_wr = (shadow_q & ~(CW'(4'hF) << digit_sh)) | (CW'(bus.digit) << digit_sh);
`else
    logic unused_prog;

    assign code_cur    = CODE_INIT;
    assign unused_prog = bus.prog;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ENTRY;
            idx_q    <= '0;
            fail_q   <= '0;
            lock_q   <= '0;
            mism_q   <= 1'b0;
`ifdef PROGRAM_CODE_EN
            code_q   <= CODE_INIT;
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            lock_q   <= lock_d;
            mism_q   <= mism_d;
`ifdef PROGRAM_CODE_EN
            code_q   <= code_d;
            shadow_q <= shadow_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        mism_d   = mism_q;
`ifdef PROGRAM_CODE_EN
        code_d   = code_q;
        shadow_d = shadow_q;
`endif
        unique case (state_q)
            ST_ENTRY: begin
                if (bus.clear) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                end else if (bus.enter) begin
                    if (idx_q == LAST_IDX) begin
                        // Verdict only after the final digit; no early reject.
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!mism_n) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end else if (({1'b0, fail_q} + 5'd1) < {1'b0, FAIL_MAX}) begin
                            state_d = ST_CLOSED;
                            fail_d  = fail_q + 4'd1;
                        end else begin
                            state_d = ST_LOCKOUT;
                            fail_d  = FAIL_MAX;
                            lock_d  = LOCK_INIT;
                        end
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        mism_d = mism_n;
                    end
                end
            end
            ST_OPEN: begin
                if (bus.clear) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                end
`ifdef PROGRAM_CODE_EN
                else if (bus.prog) begin
                    state_d = ST_PROGRAM;
                    idx_d   = '0;
                end
`endif
            end
            ST_CLOSED: begin
                if (bus.clear) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lock_q <= 16'd1) begin
                    state_d = ST_ENTRY;
                    lock_d  = '0;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q - 16'd1;
                end
            end
`ifdef PROGRAM_CODE_EN
            ST_PROGRAM: begin
                // Abort on clear or an invalid digit leaves the stored code untouched.
                if (bus.clear || (bus.enter && bad)) begin
                    state_d = ST_OPEN;
                    idx_d   = '0;
                end else if (bus.enter) begin
                    shadow_d = shadow_wr;
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_wr;
                        state_d = ST_OPEN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
                mism_d  = 1'b0;
                lock_d  = '0;
            end
        endcase
    end

    assign bus.mode      = state_q;
    assign bus.digit_idx = idx_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.lock_left = lock_q;

endmodule
